// File: rtl/vga_clock_pkg.sv
// Shared types and constants for the VGA clock pushbutton front end.
// Default timings assume the 31.5 MHz pixel clock.
package vga_clock_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } rpt_state_t;

  localparam int BTN_SEC = 0;
  localparam int BTN_MIN = 1;
  localparam int BTN_HRS = 2;

  // ~2.1 ms debounce, ~0.5 s until auto-repeat, then ~8 steps per second
  localparam int DEF_DEBOUNCE_CYCLES = 65536;
  localparam int DEF_REPEAT_DELAY    = 16000000;
  localparam int DEF_REPEAT_PERIOD   = 4000000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One-bit synchroniser followed by a stable-count debouncer.
// The clean level only changes after DEBOUNCE_CYCLES consecutive disagreeing samples.
module btn_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic level_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   level_q, level_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // Next-state logic: shift the synchroniser and run the stability counter
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw_i};
    level_d = level_q;
    cnt_d   = '0;
    if (sync_q[SYNC_STAGES-1] != level_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        level_d = ~level_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/vga_clock_button_ctrl.sv
// Time-set button conditioning for the VGA clock: debounce each pad and
// turn a press into one increment strobe, with hold-to-auto-repeat.
module vga_clock_button_ctrl
  import vga_clock_pkg::*;
#(
  parameter int NUM_BTN         = 3,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_oeb,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] inc_pulse,
  output logic               any_held
);

  localparam int RPT_W = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);

  logic [NUM_BTN-1:0] level_s;
  logic [NUM_BTN-1:0] pulse_s;
  logic               any_held_q, any_held_d;

  // Pads are input-only, so output drivers stay disabled even in reset
  assign btn_oeb = {NUM_BTN{1'b1}};

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    rpt_state_t       state_q, state_d;
    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             pulse_q, pulse_d;

    btn_debounce #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (wb_clk_i),
      .rst_n_i(wb_rst_n),
      .raw_i  (btn_raw[g]),
      .level_o(level_s[g])
    );

    // Repeat FSM; a release takes priority over a coincident terminal count
    always_comb begin
      state_d = state_q;
      rpt_d   = rpt_q;
      pulse_d = 1'b0;
      case (state_q)
        IDLE: begin
          rpt_d = '0;
          if (level_s[g]) begin
            pulse_d = 1'b1;
            state_d = DELAY;
          end else begin
            state_d = IDLE;
          end
        end
        DELAY: begin
          if (!level_s[g]) begin
            state_d = IDLE;
            rpt_d   = '0;
          end else if (rpt_q == RPT_W'(REPEAT_DELAY - 1)) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
            state_d = REPEAT;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
        end
        REPEAT: begin
          if (!level_s[g]) begin
            state_d = IDLE;
            rpt_d   = '0;
          end else if (rpt_q == RPT_W'(REPEAT_PERIOD - 1)) begin
            pulse_d = 1'b1;
            rpt_d   = '0;
          end else begin
            rpt_d = rpt_q + RPT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          rpt_d   = '0;
        end
      endcase
    end

    // FSM state, timer and registered strobe
    always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_n) begin
        state_q <= IDLE;
        rpt_q   <= '0;
        pulse_q <= 1'b0;
      end else begin
        state_q <= state_d;
        rpt_q   <= rpt_d;
        pulse_q <= pulse_d;
      end
    end

    assign pulse_s[g] = pulse_q;
  end

  // Any button currently held, one cycle behind btn_level
  always_comb begin
    any_held_d = |level_s;
  end

  // any_held register
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      any_held_q <= 1'b0;
    end else begin
      any_held_q <= any_held_d;
    end
  end

  assign btn_level = level_s;
  assign inc_pulse = pulse_s;
  assign any_held  = any_held_q;

endmodule

// File: tb/tb_vga_clock_button_ctrl.sv
// Directed bench for vga_clock_button_ctrl with short timings; expected
// increment strobes are scheduled from the press/release times into a scoreboard.
module tb_vga_clock_button_ctrl;
  import vga_clock_pkg::*;

  localparam int SS  = 2;
  localparam int DB  = 4;
  localparam int RD  = 10;
  localparam int RP  = 3;
  localparam int LAT = SS + DB;
  localparam int NOLIM = 4000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] raw;
  logic [2:0] oeb;
  logic [2:0] level;
  logic [2:0] pulse;
  logic       held;

  always #5 clk = ~clk;

  vga_clock_button_ctrl #(
    .NUM_BTN        (3),
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_PERIOD  (RP)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_n (rst_n),
    .btn_raw  (raw),
    .btn_oeb  (oeb),
    .btn_level(level),
    .inc_pulse(pulse),
    .any_held (held)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [2:0] p;
  } exp_t;
  exp_t       exp_q[$];
  logic [2:0] pmap [0:4095];

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s at cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  // Press driven at negedge t (first sampled next edge), release driven at r;
  // no strobe allowed after cycle lim (reset).
  task automatic plan(input int b, input int t, input int r, input int lim);
    int p;
    int last;
    int step;
    p    = t + LAT + 1;
    last = r + LAT;
    if (lim < last) last = lim;
    step = RD;
    while (p <= last) begin
      pmap[p][b] = 1'b1;
      p += step;
      step = RP;
    end
  endtask

  task automatic commit(input int a, input int b);
    exp_t e;
    for (int c = a; c <= b; c++) begin
      if (pmap[c] != 3'b000) begin
        e.c = c;
        e.p = pmap[c];
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Scoreboard consumer: every strobe seen must match the next scheduled one
  always @(negedge clk) begin
    if (cyc > 0 && pulse !== 3'b000) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", 32'(pulse), 32'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_cycle", 32'(cyc), 32'(e.c));
        check("pulse_pattern", 32'(pulse), 32'(e.p));
      end
    end
  end

  initial begin
    int t;
    int s;
    int u;
    int r2;
    logic seen;
    for (int i = 0; i < 4096; i++) pmap[i] = 3'b000;

    // 1: reset with all buttons pressed
    rst_n = 1'b0;
    raw   = 3'b111;
    #1;
    check("oeb_before_clock", 32'(oeb), 32'h7);
    repeat (3) begin
      @(negedge clk);
      check("rst_level", 32'(level), 32'h0);
      check("rst_pulse", 32'(pulse), 32'h0);
      check("rst_held", 32'(held), 32'h0);
      check("rst_oeb", 32'(oeb), 32'h7);
    end
    t = cyc;
    rst_n = 1'b1;
    for (int b = 0; b < 3; b++) plan(b, t, t + 8, NOLIM);
    commit(t, t + 150);
    wait_until(t + LAT - 1);
    check("s1_level_pre", 32'(level), 32'h0);
    wait_until(t + LAT);
    check("s1_level_rise", 32'(level), 32'h7);
    check("s1_held_lag", 32'(held), 32'h0);
    wait_until(t + LAT + 1);
    check("s1_held", 32'(held), 32'h1);
    wait_until(t + 8);
    raw = 3'b000;
    wait_until(t + 8 + LAT - 1);
    check("s1_level_hold", 32'(level), 32'h7);
    wait_until(t + 8 + LAT);
    check("s1_level_fall", 32'(level), 32'h0);
    wait_until(t + 40);
    check("s1_pulses_done", 32'(exp_q.size()), 32'h0);

    // 2: clean short press of the minutes button
    t = cyc;
    raw[BTN_MIN] = 1'b1;
    plan(BTN_MIN, t, t + 8, NOLIM);
    commit(t, t + 150);
    wait_until(t + LAT - 1);
    check("s2_level_pre", 32'(level[BTN_MIN]), 32'h0);
    wait_until(t + LAT);
    check("s2_level_rise", 32'(level[BTN_MIN]), 32'h1);
    wait_until(t + 8);
    raw[BTN_MIN] = 1'b0;
    wait_until(t + 8 + LAT - 1);
    check("s2_level_hold", 32'(level[BTN_MIN]), 32'h1);
    wait_until(t + 8 + LAT);
    check("s2_level_fall", 32'(level[BTN_MIN]), 32'h0);
    wait_until(t + 40);
    check("s2_pulses_done", 32'(exp_q.size()), 32'h0);

    // 3: glitches one cycle shorter than the debounce window
    t = cyc;
    seen = 1'b0;
    raw[BTN_SEC] = 1'b1;
    for (int c = t + 1; c <= t + 20; c++) begin
      wait_until(c);
      if (c == t + 3) raw[BTN_SEC] = 1'b0;
      if (c == t + 4) raw[BTN_SEC] = 1'b1;
      if (c == t + 7) raw[BTN_SEC] = 1'b0;
      seen = seen | level[BTN_SEC];
    end
    check("s3_glitch_level", 32'(seen), 32'h0);
    check("s3_no_pulses", 32'(exp_q.size()), 32'h0);

    // 4: long hold on hours, auto-repeat
    t = cyc;
    raw[BTN_HRS] = 1'b1;
    plan(BTN_HRS, t, t + 40, NOLIM);
    commit(t, t + 150);
    wait_until(t + 40);
    raw[BTN_HRS] = 1'b0;
    wait_until(t + 40 + LAT - 1);
    check("s4_level_hold", 32'(level[BTN_HRS]), 32'h1);
    wait_until(t + 40 + LAT);
    check("s4_level_fall", 32'(level[BTN_HRS]), 32'h0);
    wait_until(t + 70);
    check("s4_pulses_done", 32'(exp_q.size()), 32'h0);

    // 5: all buttons together, seconds released early
    t = cyc;
    raw = 3'b111;
    plan(BTN_SEC, t, t + 12, NOLIM);
    plan(BTN_MIN, t, t + 30, NOLIM);
    plan(BTN_HRS, t, t + 30, NOLIM);
    commit(t, t + 150);
    wait_until(t + 12);
    raw[BTN_SEC] = 1'b0;
    wait_until(t + 12 + LAT);
    check("s5_level_partial", 32'(level), 32'h6);
    wait_until(t + 30);
    raw = 3'b000;
    wait_until(t + 60);
    check("s5_pulses_done", 32'(exp_q.size()), 32'h0);

    // 6: reset while hours is auto-repeating, button still held
    t  = cyc;
    s  = t + 22;
    u  = s + 3;
    r2 = u + 25;
    raw[BTN_HRS] = 1'b1;
    plan(BTN_HRS, t, NOLIM, s);
    plan(BTN_HRS, u, r2, NOLIM);
    commit(t, t + 150);
    wait_until(s);
    rst_n = 1'b0;
    for (int c = s + 1; c <= u; c++) begin
      wait_until(c);
      check("s6_rst_pulse", 32'(pulse), 32'h0);
      check("s6_rst_level", 32'(level), 32'h0);
      check("s6_rst_oeb", 32'(oeb), 32'h7);
    end
    rst_n = 1'b1;
    wait_until(u + LAT - 1);
    check("s6_redebounce_pre", 32'(level[BTN_HRS]), 32'h0);
    wait_until(u + LAT);
    check("s6_redebounce_rise", 32'(level[BTN_HRS]), 32'h1);
    wait_until(r2);
    raw = 3'b000;
    wait_until(r2 + 40);
    check("s6_pulses_done", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
